// File: rtl/manchester_rx.sv
// Manchester (IEEE 802.3 polarity) byte receiver: start bit plus 8 data bits MSB first,
// with mid-bit edge window tracking, timeout detection and a valid/ready output register.
//
// state | meaning
// IDLE  | waiting for a start-bit rising edge after a quiet (low) line
// DATA  | sampling mid-bit edges for the 8 data bits
module manchester_rx #(
    parameter int HALF_BIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       din,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [7:0] QUIET_MAX = 8'(2 * HALF_BIT);
    localparam logic [7:0] MID_LO    = 8'(3 * HALF_BIT / 2);
    localparam logic [7:0] MID_HI    = 8'(5 * HALF_BIT / 2);
    localparam logic [7:0] TIMEOUT   = 8'(5 * HALF_BIT / 2 + 1);

    typedef enum logic {
        IDLE,
        DATA
    } state_t;

    state_t     state, state_nxt;
    logic       s1, s2, s3;
    logic       line_edge;
    logic [7:0] quiet;
    logic [7:0] cnt, cnt_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [6:0] shreg, shreg_nxt;
    logic [7:0] rx_byte;
    logic       byte_done;
    logic       timeout_err;

    assign line_edge = s2 ^ s3;
    assign rx_byte   = {shreg, s2};
    assign busy      = (state == DATA);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        byte_done   = 1'b0;
        timeout_err = 1'b0;
        if (!ena) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            bit_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_edge && s2 && (quiet == QUIET_MAX)) begin
                        state_nxt   = DATA;
                        cnt_nxt     = '0;
                        bit_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    // Edges before the window are bit-boundary transitions and are skipped.
                    if (line_edge && (cnt >= MID_LO) && (cnt <= MID_HI)) begin
                        shreg_nxt   = {shreg[5:0], s2};
                        cnt_nxt     = '0;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_done = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else if (cnt >= TIMEOUT) begin
                        timeout_err = 1'b1;
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                        bit_cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            quiet      <= '0;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            s1      <= din;
            s2      <= s1;
            s3      <= s2;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            if (s2) begin
                quiet <= '0;
            end else if (quiet != QUIET_MAX) begin
                quiet <= quiet + 8'd1;
            end
            frame_err <= timeout_err;
            overrun   <= 1'b0;
            // A byte completing on a transfer edge replaces the consumed one.
            if (byte_done) begin
                if (!data_valid || data_ready) begin
                    data_out   <= rx_byte;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_manchester_rx.sv
// Scoreboard bench for manchester_rx (HALF_BIT = 8): directed frames push expected bytes,
// a negedge monitor pops and compares on every valid/ready transfer.
module tb_manchester_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       din;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int valid_cyc = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int xfer_cnt = 0;
    logic [7:0] exp_q[$];

    manchester_rx #(.HALF_BIT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .din       (din),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int h1, input int h2);
        din = ~b;
        tick(h1);
        din = b;
        tick(h2);
    endtask

    // Start bit plus the first nbits of d, MSB first; alt gives 14/18 cycle bit periods.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit alt);
        int hb;
        send_bit(1'b1, 8, 8);
        for (int i = 0; i < nbits; i++) begin
            hb = alt ? ((i % 2 == 0) ? 7 : 9) : 8;
            send_bit(d[7-i], hb, hb);
        end
    endtask

    always @(negedge clk) begin
        if (data_valid) valid_cyc++;
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (data_valid && data_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {24'd0, data_out}, 32'hxxxx_xxxx);
            end else begin
                chk("rx_byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int v0;
        din = 1'b0;
        ena = 1'b1;
        data_ready = 1'b1;
        rst_n = 1'b0;
        tick(3);
        chk("rst_data_out", {24'd0, data_out}, 32'h0);
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_err_ovr_busy", {29'd0, frame_err, overrun, busy}, 32'd0);
        rst_n = 1'b1;
        tick(32);

        // single byte, one-cycle valid
        v0 = valid_cyc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 8, 1'b0);
        din = 1'b0;
        tick(32);
        chk("a5_valid_cycles", valid_cyc - v0, 32'd1);
        chk("a5_xfers", xfer_cnt, 32'd1);
        chk("a5_no_err", ferr_cnt + ovr_cnt, 32'd0);

        // back-to-back 0x00 and 0xFF
        exp_q.push_back(8'h00);
        send_frame(8'h00, 8, 1'b0);
        din = 1'b0;
        tick(32);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 8, 1'b0);
        din = 1'b0;
        tick(32);
        chk("00ff_xfers", xfer_cnt, 32'd3);
        chk("00ff_no_err", ferr_cnt + ovr_cnt, 32'd0);

        // overrun with consumer stalled
        data_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 8, 1'b0);
        din = 1'b0;
        tick(32);
        send_frame(8'hC3, 8, 1'b0);
        din = 1'b0;
        tick(32);
        chk("ovr_data_held", {24'd0, data_out}, 32'h3C);
        chk("ovr_valid_held", {31'd0, data_valid}, 32'd1);
        chk("ovr_pulse_cycles", ovr_cnt, 32'd1);
        chk("ovr_no_xfer", xfer_cnt, 32'd3);
        data_ready = 1'b1;
        tick(4);
        chk("ovr_valid_fall", {31'd0, data_valid}, 32'd0);
        chk("ovr_one_xfer", xfer_cnt, 32'd4);

        // frozen line after 3 data bits -> timeout
        v0 = valid_cyc;
        send_frame(8'h96, 3, 1'b0);
        din = 1'b0;
        tick(40);
        chk("timeout_err_cycles", ferr_cnt, 32'd1);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        chk("timeout_no_valid", valid_cyc - v0, 32'd0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 8, 1'b0);
        din = 1'b0;
        tick(32);
        chk("after_timeout_xfers", xfer_cnt, 32'd5);

        // jittered bit periods
        exp_q.push_back(8'h81);
        send_frame(8'h81, 8, 1'b1);
        din = 1'b0;
        tick(32);
        chk("jitter_xfers", xfer_cnt, 32'd6);
        chk("jitter_no_err", ferr_cnt, 32'd1);

        // mid-bit edge too early (cnt = 11) is ignored, then the frame times out
        send_bit(1'b1, 8, 8);
        send_bit(1'b1, 8, 8);
        din = 1'b0;
        tick(4);
        din = 1'b1;
        tick(30);
        din = 1'b0;
        tick(40);
        chk("early_edge_err", ferr_cnt, 32'd2);
        chk("early_edge_no_xfer", xfer_cnt, 32'd6);

        // reset mid-frame
        send_frame(8'hC3, 4, 1'b0);
        chk("midframe_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        din = 1'b0;
        tick(2);
        chk("mid_rst_data_out", {24'd0, data_out}, 32'h0);
        chk("mid_rst_flags", {28'd0, data_valid, frame_err, overrun, busy}, 32'd0);
        rst_n = 1'b1;
        tick(16);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 8, 1'b0);
        din = 1'b0;
        tick(32);
        chk("post_rst_xfers", xfer_cnt, 32'd7);
        chk("post_rst_errs", ferr_cnt, 32'd2);
        chk("post_rst_ovr", ovr_cnt, 32'd1);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/manchester_rx.md
MANCHESTER_RX -- requirements
Module: manchester_rx

Interface
- REQ-001 Parameter: HALF_BIT, default 8, clk cycles per Manchester half-bit (bit period = 2*HALF_BIT); legal range 4..64, even.
- REQ-002 clk  input  1  sole clock; all state updates on rising edge.
- REQ-003 rst_n  input  1  reset, asynchronous, active-low.
- REQ-004 ena  input  1  block enable; low forces receiver to IDLE.
- REQ-005 din  input  1  serial Manchester line, asynchronous to clk.
- REQ-006 data_out  output  8  received byte.
- REQ-007 data_valid  output  1  data_out holds an unconsumed byte.
- REQ-008 data_ready  input  1  consumer accepts byte when high with data_valid.
- REQ-009 frame_err  output  1  one-cycle pulse on code violation or timeout.
- REQ-010 overrun  output  1  one-cycle pulse when a completed byte is dropped.
- REQ-011 busy  output  1  high while state is DATA.

Function
- REQ-012 Line coding: IEEE 802.3 convention; mid-bit low->high = 1, high->low = 0; idle line low.
- REQ-013 Frame: start bit (value 1) then 8 data bits, MSB first; no stop bit.
- REQ-014 din passes a 2-flop synchronizer (s1, s2) plus history flop s3; edge = s2 != s3; a din change first sampled at clk edge k is acted on at edge k+2.
- REQ-015 Quiet counter: counts consecutive cycles with s2 = 0, saturates at 2*HALF_BIT, clears when s2 = 1.
- REQ-016 States: IDLE, DATA.
- REQ-017 IDLE -> DATA on a rising edge only when quiet counter = 2*HALF_BIT; bit counter cleared, cycle counter cnt cleared; rising edges with quiet < 2*HALF_BIT ignored.
- REQ-018 In DATA cnt increments each cycle; edges with cnt < 3*HALF_BIT/2 are bit-boundary edges and ignored.
- REQ-019 Edge with 3*HALF_BIT/2 <= cnt <= 5*HALF_BIT/2 (inclusive) is a mid-bit edge: bit = s2 after the edge, shifted in at LSB, cnt cleared, bit counter +1.
- REQ-020 cnt reaching 5*HALF_BIT/2 + 1 without a mid-bit edge: frame_err pulses one cycle, partial byte discarded, -> IDLE.
- REQ-021 On the 8th data bit: -> IDLE; byte delivered per REQ-022/023 on that same clk edge (data_valid high 2 cycles after final transition sampled).
- REQ-022 Handshake: transfer when data_valid & data_ready at a clk edge; data_valid and data_out then hold until transfer; data_valid drops on the transfer edge unless a new byte loads that edge.
- REQ-023 Byte completes while data_valid high and no transfer that edge: overrun pulses one cycle, new byte dropped, data_out unchanged; completion coincident with transfer: new byte loaded, data_valid stays high, no overrun.
- REQ-024 ena low: state -> IDLE, bit/cycle counters cleared, no frame_err; synchronizer, quiet counter, data_out/data_valid handshake continue operating.
- REQ-025 frame_err and overrun never assert together with a valid byte load from the same frame.

Reset
- REQ-026 rst_n low asynchronously sets: state IDLE, s1/s2/s3 0, quiet 0, cnt 0, bit counter 0, data_out 0x00, data_valid 0, frame_err 0, overrun 0, busy 0.
- REQ-027 After rst_n release, no start accepted until line low 2*HALF_BIT cycles; reset mid-frame discards the frame without frame_err.

Verification (HALF_BIT = 8)
- REQ-028 din low 32 cycles, frame 0xA5 at 16 cycles/bit, data_ready = 1 -> data_valid high exactly 1 cycle, data_out = 0xA5, frame_err = 0, overrun = 0.
- REQ-029 Frames 0x00 then 0xFF (all bit-boundary edges present), 32-cycle low gap, data_ready = 1 -> bytes 0x00, 0xFF in order, no errors.
- REQ-030 data_ready = 0, frames 0x3C then 0xC3 -> data_out 0x3C held, overrun 1-cycle pulse at second completion; then data_ready = 1 -> one transfer of 0x3C, data_valid falls.
- REQ-031 Frame 0x96 with din frozen after bit 3 -> frame_err pulse when cnt = 21, no data_valid, busy 0; following frame 0x55 received correctly.
- REQ-032 Frame 0x81 with bit periods alternating 14 and 18 cycles -> 0x81 received; a mid-bit edge moved to cnt = 11 -> frame_err.
- REQ-033 rst_n pulsed low after 4 data bits -> all outputs 0 within the reset pulse, no frame_err; next frame 0x81 after 16 quiet cycles received correctly.
